wave_capture_ctrl: RTL
======================

WAVE_CAPTURE_CTRL -- requirements
Module: wave_capture_ctrl

Interface
REQ-001 SHALL have parameter: HYST_THRESH, 16'sd256, trigger re-arm threshold (magnitude); used only when WAVE_HYSTERESIS_EN is defined.
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: new_sample_ready  input  1  one-cycle pulse, new audio sample valid; pulses may be back-to-back.
REQ-005 SHALL have port: new_sample_in  input  16  signed two's-complement audio sample, valid with new_sample_ready.
REQ-006 SHALL have port: wave_display_idle  input  1  level, high while display is outside the active waveform window (blanking).
REQ-007 SHALL have port: write_address  output  9  sample RAM write address {buffer, index[7:0]}.
REQ-008 SHALL have port: write_enable  output  1  sample RAM write strobe, one cycle per captured sample.
REQ-009 SHALL have port: write_sample  output  8  offset-binary captured sample.
REQ-010 SHALL have port: read_index  output  1  selects RAM half the display reads; capture writes the other half.
REQ-011 SHALL have port: capture_state  output  2  current FSM state (ARMED=0, ACTIVE=1, WAIT=2), for debug.

Function
REQ-012 SHALL implement FSM with states ARMED, ACTIVE, WAIT; encoding 3 unused, decodes to ARMED on next cycle.
REQ-013 SHALL keep prev_sample register, loaded with new_sample_in on every new_sample_ready in all states.
REQ-014 ARMED: on new_sample_ready with trigger true -> write sample at index 0, count=1, go ACTIVE; otherwise stay, no write.
REQ-015 Trigger (macro undefined): prev_sample < 0 and new_sample_in >= 0 (positive-going zero crossing).
REQ-016 ACTIVE: each new_sample_ready writes at index count, count increments; the write at count 255 moves to WAIT, count wraps to 0.
REQ-017 WAIT: no writes; samples ignored except prev_sample update; when wave_display_idle=1, toggle read_index and go ARMED in the same cycle.
REQ-018 Write outputs SHALL be registered: write_enable, write_address, write_sample valid exactly one cycle after the qualifying new_sample_ready; write_enable low otherwise.
REQ-019 write_address SHALL be {~read_index, index[7:0]}; read_index never changes during ARMED or ACTIVE.
REQ-020 write_sample SHALL be new_sample_in[15:8] with MSB inverted (-32768 -> 8'h00, 0 -> 8'h80, 32767 -> 8'hFF).
REQ-021 Exactly 256 writes per captured frame; no write reaches the half selected by read_index.
REQ-022 wave_display_idle already high on entry to WAIT: flip occurs on first WAIT cycle (WAIT lasts one cycle).
REQ-023 new_sample_ready coincident with WAIT->ARMED cycle SHALL NOT trigger (state is WAIT for that sample).

Reset
REQ-024 reset SHALL force: state ARMED, read_index 0, count 0, prev_sample 0, write_enable 0, write_address 0, write_sample 0, hysteresis armed flag 0.
REQ-025 reset asserted mid-ACTIVE SHALL abort capture; no write_enable in the cycle after reset; partially written half left as-is.

Configuration
REQ-026 Macro WAVE_HYSTERESIS_EN SHALL compile in trigger hysteresis.
REQ-027 With WAVE_HYSTERESIS_EN: in ARMED an armed flag sets when new_sample_in <= -HYST_THRESH; trigger = flag set and new_sample_in >= 0; flag clears on trigger and on entry to ARMED.
REQ-028 Without WAVE_HYSTERESIS_EN: REQ-015 trigger, no flag register, HYST_THRESH unused.

Structure
REQ-029 Shared package wave_pkg SHALL hold state enum, SAMPLES_PER_FRAME=256, ADDR_W=9, SAMPLE_W=16, DISP_W=8.
REQ-030 Trigger logic SHALL be one sub-module, wave_trigger (prev/current samples in, trigger out, optional hysteresis flag); FSM, counter and write regs in wave_capture_ctrl; all flops via dffre/dffr.

Verification
REQ-031 Samples -100, +50 after reset -> write_enable one cycle after the +50 pulse, address 9'h100, data 8'h80; state ACTIVE.
REQ-032 Trigger then 255 more pulses (ramp) -> exactly 256 writes, addresses 9'h100..9'h1FF, state WAIT, no 257th write.
REQ-033 In WAIT hold wave_display_idle=0 for 1000 cycles then 1 -> read_index 0->1 next edge; next capture writes 9'h000..9'h0FF.
REQ-034 reset after 10 writes of ACTIVE -> all outputs zero, state ARMED; new crossing restarts at address 9'h100.
REQ-035 Macro defined, HYST_THRESH=256: samples -100, +50 -> no trigger; samples -300, -10, +5 -> trigger on +5, data 8'h80.
REQ-036 new_sample_ready every cycle (back-to-back) -> 256 consecutive write_enable cycles, contiguous addresses, no drops.

Source files
------------

// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared types, sizes and sample conversion for the waveform capture block
package wave_pkg;
    localparam int SAMPLES_PER_FRAME = 256;
    localparam int ADDR_W            = 9;
    localparam int SAMPLE_W          = 16;
    localparam int DISP_W            = 8;

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } capture_state_t;

    // Offset-binary: top byte of the sample with the sign bit flipped.
    function automatic logic [DISP_W-1:0] to_display(input logic [SAMPLE_W-1:0] s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2 -: DISP_W-1]};
    endfunction
endpackage

// File: rtl/dffr.sv
// rtl/dffr.sv - register with synchronous active-high clear
module dffr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end
endmodule

// File: rtl/dffre.sv
// rtl/dffre.sv - register with load enable and synchronous active-high clear
module dffre #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/wave_trigger.sv
// rtl/wave_trigger.sv - capture trigger; WAVE_HYSTERESIS_EN selects armed-flag hysteresis over plain zero crossing
module wave_trigger #(
    parameter logic signed [15:0] HYST_THRESH = 16'sd256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic        armed,
    input  logic        arm_entry,
    input  logic [15:0] prev_sample,
    input  logic [15:0] sample,
    output logic        trigger
);
`ifdef WAVE_HYSTERESIS_EN
    logic flag_q;
    logic flag_en;
    logic flag_d;
    logic unused_prev;

    // The signal must first dip below -HYST_THRESH before a non-negative sample can fire.
    assign trigger     = flag_q && !sample[15];
    assign flag_en     = arm_entry ||
                         (armed && sample_valid && (trigger || ($signed(sample) <= -HYST_THRESH)));
    assign flag_d      = !(arm_entry || trigger);
    assign unused_prev = ^prev_sample;

    dffre #(.W(1)) u_flag (
        .clk   (clk),
        .reset (reset),
        .en    (flag_en),
        .d     (flag_d),
        .q     (flag_q)
    );
`else
    logic unused_inputs;

    assign trigger       = prev_sample[15] && !sample[15];
    assign unused_inputs = ^{clk, reset, sample_valid, armed, arm_entry, HYST_THRESH};
`endif
endmodule

// File: rtl/wave_capture_ctrl.sv
// rtl/wave_capture_ctrl.sv - double-buffered oscilloscope capture FSM; WAVE_HYSTERESIS_EN enables trigger hysteresis
module wave_capture_ctrl
    import wave_pkg::*;
#(
    parameter logic signed [15:0] HYST_THRESH = 16'sd256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_sample_ready,
    input  logic [15:0] new_sample_in,
    input  logic        wave_display_idle,
    output logic [8:0]  write_address,
    output logic        write_enable,
    output logic [7:0]  write_sample,
    output logic        read_index,
    output logic [1:0]  capture_state
);
    logic [1:0]  state_q, state_d;
    logic [7:0]  count_q, count_d, idx;
    logic        read_d;
    logic        we_d;
    logic [8:0]  wa_d;
    logic [7:0]  ws_d;
    logic [15:0] prev_q;
    logic        trig;
    logic        arm_entry;

    wave_trigger #(.HYST_THRESH(HYST_THRESH)) u_trigger (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (new_sample_ready),
        .armed        (state_q == ST_ARMED),
        .arm_entry    (arm_entry),
        .prev_sample  (prev_q),
        .sample       (new_sample_in),
        .trigger      (trig)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        read_d    = read_index;
        we_d      = 1'b0;
        idx       = count_q;
        arm_entry = 1'b0;
        case (state_q)
            ST_ARMED: begin
                if (new_sample_ready && trig) begin
                    we_d    = 1'b1;
                    idx     = 8'd0;
                    count_d = 8'd1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (new_sample_ready) begin
                    we_d    = 1'b1;
                    count_d = count_q + 8'd1;
                    if (count_q == 8'(SAMPLES_PER_FRAME - 1)) state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Swap halves only while the display is blanked so it never tears.
                if (wave_display_idle) begin
                    read_d    = ~read_index;
                    state_d   = ST_ARMED;
                    arm_entry = 1'b1;
                end
            end
            default: begin
                state_d   = ST_ARMED;
                arm_entry = 1'b1;
            end
        endcase
        wa_d = we_d ? {~read_index, idx} : write_address;
        ws_d = we_d ? to_display(new_sample_in) : write_sample;
    end

    dffr  #(.W(2))  u_state (.clk(clk), .reset(reset), .d(state_d), .q(state_q));
    dffr  #(.W(8))  u_count (.clk(clk), .reset(reset), .d(count_d), .q(count_q));
    dffr  #(.W(1))  u_read  (.clk(clk), .reset(reset), .d(read_d),  .q(read_index));
    dffr  #(.W(1))  u_we    (.clk(clk), .reset(reset), .d(we_d),    .q(write_enable));
    dffr  #(.W(9))  u_wa    (.clk(clk), .reset(reset), .d(wa_d),    .q(write_address));
    dffr  #(.W(8))  u_ws    (.clk(clk), .reset(reset), .d(ws_d),    .q(write_sample));
    dffre #(.W(16)) u_prev  (.clk(clk), .reset(reset), .en(new_sample_ready),
                             .d(new_sample_in), .q(prev_q));

    assign capture_state = state_q;
endmodule
